bus_write_seq: RTL and testbench
================================

BUS_WRITE_SEQ -- requirements
Module: bus_write_seq

Interface
REQ-001 Parameter DEPTH, default 4, is the write-queue depth and SHALL be a power of two, minimum 2.
REQ-002 Parameter WIDTH, default 16, is the data width and SHALL match the downstream four-register bus.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_data  input  WIDTH  write payload.
REQ-006 in_sel  input  2  destination: 0=a, 1=b, 2=c, 3=d.
REQ-007 in_bcast  input  1  when 1, the write goes to all four registers and in_sel is ignored.
REQ-008 in_valid  input  1  request present.
REQ-009 in_ready  output  1  queue can accept a request.
REQ-010 hold  input  1  stalls issue to the bus; does not stall acceptance.
REQ-011 data  output  WIDTH  bus data to the register block.
REQ-012 a_en, b_en, c_en, d_en  output  1 each  write enables to the register block.
REQ-013 count  output  log2(DEPTH)+1  current queue occupancy.

Function
REQ-014 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-015 Each accepted request SHALL store {in_data, in_sel, in_bcast} at the queue tail.
REQ-016 in_ready SHALL equal (count < DEPTH), decoded from registered state only.
REQ-017 A full queue SHALL NOT accept, even if an issue occurs in the same cycle.
REQ-018 Issue SHALL occur on a rising edge where count > 0 and hold=0, popping the head entry.
REQ-019 On issue, data SHALL be registered with the head payload on that same edge.
REQ-020 On issue, exactly the selected enable SHALL be registered to 1 on that same edge, or all four if bcast=1.
REQ-021 Enables SHALL be high for exactly one cycle per issued entry; back-to-back issues MAY keep an enable high on consecutive cycles.
REQ-022 On any edge without an issue, all four enables SHALL be registered to 0 and data SHALL hold its last value.
REQ-023 Latency: a request accepted into an empty queue at edge N with hold=0 SHALL drive its enable(s) high between edges N+1 and N+2, so the register block captures it at edge N+2.
REQ-024 Ordering SHALL be strict FIFO; no reordering by destination.
REQ-025 Simultaneous accept and issue SHALL leave count unchanged.
REQ-026 Accept alone SHALL increment count; issue alone SHALL decrement count.
REQ-027 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-028 An accept into an empty queue SHALL NOT issue on the same edge; there is no bypass path.
REQ-029 hold=1 SHALL freeze the pointers' issue side and force the enables to 0 on the next edge; acceptance continues until full.
REQ-030 in_sel/in_bcast values on cycles with no accept SHALL have no effect.

Reset
REQ-031 reset=1 at a rising edge SHALL set data=0, a_en=b_en=c_en=d_en=0, count=0, both pointers=0, and in_ready=1 after that edge.
REQ-032 Reset SHALL override a simultaneous accept or issue: no entry is stored and no enable is asserted.
REQ-033 Reset mid-operation SHALL discard all queued entries.
REQ-034 No enable SHALL pulse in the cycle after reset is deasserted unless an entry was accepted after reset.

Verification
REQ-035 Basic write: after reset, accept {0x1234, sel=2, bcast=0} -> c_en=1 and data=0x1234 for one cycle, exactly two edges after acceptance; a/b/d_en stay 0.
REQ-036 Broadcast: accept {0xBEEF, bcast=1, sel=1} -> a_en=b_en=c_en=d_en=1 for one cycle with data=0xBEEF.
REQ-037 Fill and backpressure: hold=1, present 5 requests (data 0..4) with DEPTH=4 -> count reaches 4, in_ready=0, and the 5th is not accepted until hold drops. Then hold=0 -> data issues 0,1,2,3 on consecutive cycles, then 4.
REQ-038 Wrap-around and simultaneous push/pop: stream 10 requests with in_valid=1 and hold=0 continuously -> count stays at 1 after the first, ordering is preserved across pointer wrap, and one enable pulses per cycle.
REQ-039 Reset mid-operation: queue 3 entries with hold=1, assert reset for one edge, release hold -> no enable pulses, count=0, data=0.
REQ-040 Hold mid-stream: assert hold for 2 cycles during a drain -> enables are 0 for exactly 2 cycles, data is unchanged, and issue resumes with the next entry in order.

Source files
------------

// File: rtl/bus_write_seq.sv
// bus_write_seq: small write queue that issues one-cycle write strobes
// to a four-register block (a, b, c, d), with optional broadcast.
module bus_write_seq #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [1:0]                 in_sel,
  input  logic                       in_bcast,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       hold,
  output logic [WIDTH-1:0]           data,
  output logic                       a_en,
  output logic                       b_en,
  output logic                       c_en,
  output logic                       d_en,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_data  [DEPTH];
  logic [1:0]       mem_sel   [DEPTH];
  logic             mem_bcast [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [3:0]    en_q;
  logic          accept;
  logic          issue;
  logic [3:0]    head_en;

  // Handshake decode from registered occupancy only; an empty queue never
  // issues, so a fresh entry always waits one edge before reaching the bus.
  always_comb begin
    in_ready = (count < FULL_COUNT);
    accept   = in_valid && in_ready;
    issue    = (count != '0) && !hold;
    head_en  = mem_bcast[rd_ptr] ? 4'hF : (4'b0001 << mem_sel[rd_ptr]);
  end

  // Queue storage: written at the tail on accept, never while in reset.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      mem_data[wr_ptr]  <= in_data;
      mem_sel[wr_ptr]   <= in_sel;
      mem_bcast[wr_ptr] <= in_bcast;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (issue)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({accept, issue})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Bus side: strobe the head entry's enables for one cycle, data holds
  // its last issued value whenever nothing is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
      en_q <= 4'h0;
    end else if (issue) begin
      data <= mem_data[rd_ptr];
      en_q <= head_en;
    end else begin
      en_q <= 4'h0;
    end
  end

  assign a_en = en_q[0];
  assign b_en = en_q[1];
  assign c_en = en_q[2];
  assign d_en = en_q[3];

endmodule

// File: tb/tb_bus_write_seq.sv
// Testbench for bus_write_seq: directed vectors with hand-checked points,
// plus a queue-based reference model compared on every cycle.
module tb_bus_write_seq;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_bcast;
  logic             in_valid;
  logic             in_ready;
  logic             hold;
  logic [WIDTH-1:0] data;
  logic             a_en, b_en, c_en, d_en;
  logic [CW-1:0]    count;

  int checks   = 0;
  int failures = 0;

  bus_write_seq #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_bcast (in_bcast),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .hold     (hold),
    .data     (data),
    .a_en     (a_en),
    .b_en     (b_en),
    .c_en     (c_en),
    .d_en     (d_en),
    .count    (count)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [1:0]       s;
    logic             b;
  } entry_t;

  entry_t           model_q[$];
  entry_t           model_head;
  entry_t           model_new;
  logic             model_valid = 1'b0;
  logic             model_issue;
  logic             model_accept;
  logic [WIDTH-1:0] exp_data;
  logic [3:0]       exp_en;
  logic [CW-1:0]    exp_count;
  logic             exp_ready;

  // Reference model: a plain FIFO of requests; on each edge the head is
  // popped onto the bus if allowed, and a new request joins the tail if room.
  always @(posedge clk) begin
    if (reset) begin
      model_q.delete();
      exp_en      = 4'h0;
      exp_data    = '0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      model_issue  = (model_q.size() > 0) && !hold;
      model_accept = in_valid && (model_q.size() < DEPTH);
      if (model_issue) begin
        model_head = model_q.pop_front();
        exp_data   = model_head.d;
        exp_en     = model_head.b ? 4'hF : (4'b0001 << model_head.s);
      end else begin
        exp_en = 4'h0;
      end
      if (model_accept) begin
        model_new.d = in_data;
        model_new.s = in_sel;
        model_new.b = in_bcast;
        model_q.push_back(model_new);
      end
    end
    exp_count = CW'(model_q.size());
    exp_ready = (model_q.size() < DEPTH);
  end

  // Single comparison point used by both the per-cycle compare and the
  // hand-computed spot checks.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t",
               name, actual, expected, $time);
    end
  endtask

  // Every cycle after the first reset, DUT outputs must track the model.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("model_data",  32'(data), 32'(exp_data));
      checkOutput("model_en",    32'({d_en, c_en, b_en, a_en}), 32'(exp_en));
      checkOutput("model_count", 32'(count), 32'(exp_count));
      checkOutput("model_ready", 32'(in_ready), 32'(exp_ready));
    end
  end

  // Drive one cycle of inputs, then return at the following negedge so the
  // outputs reflect the rising edge that consumed them.
  task automatic applyStimulus(input logic rst, input logic vld,
                               input logic [WIDTH-1:0] d, input logic [1:0] s,
                               input logic bc, input logic hd);
    reset    = rst;
    in_valid = vld;
    in_data  = d;
    in_sel   = s;
    in_bcast = bc;
    hold     = hd;
    @(negedge clk);
  endtask

  function automatic logic [31:0] enVec();
    return 32'({d_en, c_en, b_en, a_en});
  endfunction

  // Directed scenarios with hand-computed expectations.
  initial begin
    $display("[TB] start");
    applyStimulus(1, 0, 16'h0, 2'd0, 0, 0);
    applyStimulus(1, 1, 16'hFFFF, 2'd3, 1, 0);
    checkOutput("reset_data",  32'(data), 32'h0);
    checkOutput("reset_en",    enVec(), 32'h0);
    checkOutput("reset_count", 32'(count), 32'h0);
    checkOutput("reset_ready", 32'(in_ready), 32'h1);

    // First cycle out of reset: nothing was accepted, so no enable.
    applyStimulus(0, 0, 16'h9999, 2'd1, 1, 0);
    checkOutput("post_reset_en", enVec(), 32'h0);

    // Basic write to register c.
    applyStimulus(0, 1, 16'h1234, 2'd2, 0, 0);
    checkOutput("basic_accept_en",    enVec(), 32'h0);
    checkOutput("basic_accept_count", 32'(count), 32'h1);
    applyStimulus(0, 0, 16'h0, 2'd0, 1, 0);
    checkOutput("basic_issue_en",   enVec(), 32'h4);
    checkOutput("basic_issue_data", 32'(data), 32'h1234);
    applyStimulus(0, 0, 16'h0, 2'd3, 0, 0);
    checkOutput("basic_after_en",   enVec(), 32'h0);
    checkOutput("basic_after_data", 32'(data), 32'h1234);

    // Broadcast ignores in_sel.
    applyStimulus(0, 1, 16'hBEEF, 2'd1, 1, 0);
    applyStimulus(0, 0, 16'h0, 2'd0, 0, 0);
    checkOutput("bcast_en",   enVec(), 32'hF);
    checkOutput("bcast_data", 32'(data), 32'hBEEF);
    applyStimulus(0, 0, 16'h0, 2'd0, 0, 0);
    checkOutput("bcast_after_en", enVec(), 32'h0);

    // Fill under hold, then drain in order.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 16'(i), 2'(i % 4), 0, 1);
      if (i == 3) checkOutput("fill_count4", 32'(count), 32'h4);
    end
    checkOutput("full_count", 32'(count), 32'h4);
    checkOutput("full_ready", 32'(in_ready), 32'h0);
    checkOutput("full_en",    enVec(), 32'h0);
    applyStimulus(0, 1, 16'd4, 2'd0, 0, 0);
    checkOutput("drain0_data",  32'(data), 32'h0);
    checkOutput("drain0_count", 32'(count), 32'h3);
    applyStimulus(0, 1, 16'd4, 2'd0, 0, 0);
    checkOutput("drain1_data",  32'(data), 32'h1);
    checkOutput("drain1_count", 32'(count), 32'h3);
    for (int i = 2; i < 5; i++) begin
      applyStimulus(0, 0, 16'h0, 2'd0, 0, 0);
      checkOutput("drain_data", 32'(data), 32'(i));
    end
    applyStimulus(0, 0, 16'h0, 2'd0, 0, 0);
    checkOutput("drain_done_en", enVec(), 32'h0);

    // Continuous stream across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 16'(16'h0100 + i), 2'(i % 4), 0, 0);
      checkOutput("stream_count", 32'(count), 32'h1);
      if (i == 0) begin
        checkOutput("stream_first_en", enVec(), 32'h0);
      end else begin
        checkOutput("stream_data", 32'(data), 32'(16'h0100 + i - 1));
        checkOutput("stream_en",   enVec(), 32'(4'b0001 << ((i - 1) % 4)));
      end
    end
    applyStimulus(0, 0, 16'h0, 2'd0, 0, 0);
    checkOutput("stream_last_data", 32'(data), 32'h0109);
    checkOutput("stream_end_count", 32'(count), 32'h0);

    // Reset with entries pending discards them.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 16'(16'h55 + i), 2'(i), 0, 1);
    checkOutput("pre_reset_count", 32'(count), 32'h3);
    applyStimulus(1, 1, 16'h7777, 2'd1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 16'h0, 2'd0, 0, 0);
      checkOutput("midreset_en",    enVec(), 32'h0);
      checkOutput("midreset_count", 32'(count), 32'h0);
      checkOutput("midreset_data",  32'(data), 32'h0);
    end

    // Hold for two cycles in the middle of a drain.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'(16'hA0 + i), 2'(i), 0, 1);
    applyStimulus(0, 0, 16'h0, 2'd0, 0, 0);
    checkOutput("hm_a0_data", 32'(data), 32'hA0);
    applyStimulus(0, 0, 16'h0, 2'd0, 0, 0);
    checkOutput("hm_a1_data", 32'(data), 32'hA1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 16'h0, 2'd3, 1, 1);
      checkOutput("hm_hold_en",   enVec(), 32'h0);
      checkOutput("hm_hold_data", 32'(data), 32'hA1);
    end
    applyStimulus(0, 0, 16'h0, 2'd0, 0, 0);
    checkOutput("hm_a2_data", 32'(data), 32'hA2);
    checkOutput("hm_a2_en",   enVec(), 32'h4);
    applyStimulus(0, 0, 16'h0, 2'd0, 0, 0);
    checkOutput("hm_a3_data", 32'(data), 32'hA3);
    applyStimulus(0, 0, 16'h0, 2'd0, 0, 0);
    checkOutput("hm_end_en",    enVec(), 32'h0);
    checkOutput("hm_end_count", 32'(count), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
